// File: rtl/mux4_sched_pkg.sv
// Shared types and helpers for the 4-source round-robin mux scheduler.
// Select encoding follows the mux legs: a=0, b=1, c=2, d=3.
package mux4_sched_pkg;

  localparam int N_SRC = 4;
  localparam int SL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [SL_W-1:0] idx);
    logic [N_SRC-1:0] res;
    res = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

  function automatic logic [SL_W-1:0] encode(input logic [N_SRC-1:0] oh);
    logic [SL_W-1:0] res;
    res = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (oh[i]) res = SL_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after ptr, wrapping back to ptr itself.
module rr_pick4
  import mux4_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SL_W-1:0]  ptr,
  output logic [SL_W-1:0]  pick,
  output logic             any
);

  logic [SL_W-1:0]  candIdx [N_SRC];
  logic [N_SRC-1:0] rotReq;

  // Slot gi holds source ptr+gi+1; the last slot wraps to ptr so the previous owner ranks lowest.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : gCand
      assign candIdx[gi] = ptr + SL_W'(gi + 1);
      assign rotReq[gi]  = req[candIdx[gi]];
    end
  endgenerate

  always_comb begin
    pick = ptr;
    any  = |req;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rotReq[k]) pick = candIdx[k];
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin burst scheduler driving the select of a 4-way mux; each grant is metered
// as up to MAX_BURST beats under a valid/ready handshake, with same-edge handover.
module mux4_rr_sched
  import mux4_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             out_rdy,
  output logic [3:0]       gnt,
  output logic [1:0]       sl,
  output logic             out_vld,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           stateReg, stateNext;
  logic [SL_W-1:0]  ptrReg, ptrNext;
  logic [SL_W-1:0]  slReg, slNext;
  logic [N_SRC-1:0] gntReg, gntNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  logic             ownerReq, beat, release_;
  logic [N_SRC-1:0] relReq;
  logic [SL_W-1:0]  idlePick, relPick;
  logic             idleAny, relAny;

  // While busy, sl is the owner and equals ptr.
  assign ownerReq = req[slReg];
  assign out_vld  = (stateReg == BUSY) && ownerReq;
  assign beat     = out_vld && out_rdy;
  assign release_ = (beat && (cntReg == LAST_BEAT)) || !ownerReq;
  assign relReq   = req & ~onehot(slReg);

  rr_pick4 uIdlePick (
    .req  (req),
    .ptr  (ptrReg),
    .pick (idlePick),
    .any  (idleAny)
  );

  // Owner is masked here so a lone requester at its burst limit must pass through IDLE.
  rr_pick4 uRelPick (
    .req  (relReq),
    .ptr  (ptrReg),
    .pick (relPick),
    .any  (relAny)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      ptrReg   <= SL_W'(N_SRC - 1);
      slReg    <= '0;
      gntReg   <= '0;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      ptrReg   <= ptrNext;
      slReg    <= slNext;
      gntReg   <= gntNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    ptrNext   = ptrReg;
    slNext    = slReg;
    gntNext   = gntReg;
    cntNext   = cntReg;
    unique case (stateReg)
      IDLE: begin
        if (idleAny) begin
          stateNext = BUSY;
          ptrNext   = idlePick;
          slNext    = idlePick;
          gntNext   = onehot(idlePick);
          cntNext   = '0;
        end
      end
      BUSY: begin
        if (release_) begin
          cntNext = '0;
          if (relAny) begin
            ptrNext = relPick;
            slNext  = relPick;
            gntNext = onehot(relPick);
          end else begin
            stateNext = IDLE;
            gntNext   = '0;
          end
        end else if (beat) begin
          cntNext = cntReg + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        gntNext   = '0;
        cntNext   = '0;
      end
    endcase
  end

  assign gnt      = gntReg;
  assign sl       = slReg;
  assign beat_cnt = cntReg;
  assign busy     = (stateReg == BUSY);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: reset, rotation, back-pressure, early drop,
// sole requester and asynchronous reset mid-burst.
module tb_mux4_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_rdy;
  logic [3:0] gnt;
  logic [1:0] sl;
  logic       out_vld;
  logic [3:0] beat_cnt;
  logic       busy;

  int checkCnt = 0;
  int errCnt   = 0;

  mux4_rr_sched #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .out_rdy  (out_rdy),
    .gnt      (gnt),
    .sl       (sl),
    .out_vld  (out_vld),
    .beat_cnt (beat_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("chk %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int idx);
    logic [3:0] r;
    r = 4'b0001 << idx;
    return r;
  endfunction

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // 1 Reset with all requests pending
    rst_n = 1'b0; req = 4'hF; out_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sl", 32'(sl), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_vld", 32'(out_vld), 32'h0);
    chk("rst_cnt", 32'(beat_cnt), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("pre_gnt", 32'(gnt), 32'h0);
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_sl", 32'(sl), 32'h0);
    chk("first_busy", 32'(busy), 32'h1);

    // 2 Rotation, 4 beats per owner, no idle cycles
    out_rdy = 1'b1;
    for (int o = 0; o < 5; o++) begin
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("rot_gnt_o%0d_b%0d", o, b), 32'(gnt), 32'(oh(order[o])));
        chk($sformatf("rot_cnt_o%0d_b%0d", o, b), 32'(beat_cnt), 32'(b));
        chk($sformatf("rot_vld_o%0d_b%0d", o, b), 32'(out_vld), 32'h1);
        tick();
      end
    end
    chk("rot_end_gnt", 32'(gnt), 32'h2);

    // 3 Back-pressure on owner 2
    repeat (4) tick();
    chk("bp_owner", 32'(gnt), 32'h4);
    repeat (2) tick();
    chk("bp_cnt_start", 32'(beat_cnt), 32'h2);
    out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold_cnt%0d", i), 32'(beat_cnt), 32'h2);
      chk($sformatf("bp_hold_gnt%0d", i), 32'(gnt), 32'h4);
    end
    out_rdy = 1'b1;
    tick();
    chk("bp_resume_cnt", 32'(beat_cnt), 32'h3);
    tick();
    chk("bp_rot_gnt", 32'(gnt), 32'h8);
    chk("bp_rot_cnt", 32'(beat_cnt), 32'h0);

    // 4 Early drop by owner 1 after 2 beats
    repeat (8) tick();
    chk("drop_owner", 32'(gnt), 32'h2);
    repeat (2) tick();
    chk("drop_cnt", 32'(beat_cnt), 32'h2);
    req = 4'b1000;
    #1;
    chk("drop_vld", 32'(out_vld), 32'h0);
    tick();
    chk("drop_gnt", 32'(gnt), 32'h8);
    chk("drop_sl", 32'(sl), 32'h3);
    chk("drop_cnt0", 32'(beat_cnt), 32'h0);

    // 5 Sole requester 2: handover, 4 beats, one IDLE cycle, re-grant
    req = 4'b0100;
    tick();
    chk("sole_gnt", 32'(gnt), 32'h4);
    repeat (3) tick();
    chk("sole_cnt3", 32'(beat_cnt), 32'h3);
    tick();
    chk("sole_idle_gnt", 32'(gnt), 32'h0);
    chk("sole_idle_busy", 32'(busy), 32'h0);
    chk("sole_idle_sl", 32'(sl), 32'h2);
    chk("sole_idle_vld", 32'(out_vld), 32'h0);
    tick();
    chk("sole_regnt", 32'(gnt), 32'h4);
    chk("sole_regnt_cnt", 32'(beat_cnt), 32'h0);

    // 6 Async reset mid-burst, then restart from source 0
    repeat (2) tick();
    chk("ar_cnt", 32'(beat_cnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_cnt0", 32'(beat_cnt), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_sl", 32'(sl), 32'h0);
    chk("ar_vld", 32'(out_vld), 32'h0);
    req = 4'hF;
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_restart_gnt", 32'(gnt), 32'h1);
    chk("ar_restart_sl", 32'(sl), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
